// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data memory slice: RAM_CTRL field positions,
// access-size encodings, wait-state FSM states and the alignment helpers
// used by both the top level and the testbench.
// ----------------------------------------------------------------------------
package dmem_pkg;

   // Bit positions inside RAM_CTRL
   localparam int CTRL_E       = 3;
   localparam int CTRL_RW      = 2;
   localparam int CTRL_SIZE_HI = 1;
   localparam int CTRL_SIZE_LO = 0;

   // Width of the wait-state down-counter
   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // An access is misaligned when the address bits that the size ignores
   // are set; the reserved size is always flagged.
   function automatic logic is_misaligned(input logic [7:0] addr, input logic [1:0] size);
      logic result;
      result = 1'b0;
      case (size_e'(size))
         SIZE_HALF: result = addr[0];
         SIZE_WORD: result = (addr[1:0] != 2'b00);
         SIZE_RSVD: result = 1'b1;
         default:   result = 1'b0;
      endcase
      return result;
   endfunction

   // Forced alignment: halves drop bit 0, words drop bits 1:0.
   function automatic logic [7:0] align_addr(input logic [7:0] addr, input logic [1:0] size);
      logic [7:0] result;
      result = addr;
      case (size_e'(size))
         SIZE_HALF: result = {addr[7:1], 1'b0};
         SIZE_WORD: result = {addr[7:2], 2'b00};
         default:   result = addr;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/dmem_if.sv
// ----------------------------------------------------------------------------
// dmem_if
// Pipeline-side bus of the data memory.
//   A        : byte address            DataIn   : store data
//   RAM_CTRL : {E, RW, size[1:0]}      DataOut  : load data
//   busy     : stall request           ready    : access completes this cycle
//   misalign : address not aligned to size, or reserved size
// master = pipeline side, slave = memory side.
// ----------------------------------------------------------------------------
interface dmem_if;
   logic [7:0]  A;
   logic [31:0] DataIn;
   logic [3:0]  RAM_CTRL;
   logic [31:0] DataOut;
   logic        busy;
   logic        ready;
   logic        misalign;

   modport master (
      output A, DataIn, RAM_CTRL,
      input  DataOut, busy, ready, misalign
   );

   modport slave (
      input  A, DataIn, RAM_CTRL,
      output DataOut, busy, ready, misalign
   );
endinterface

// File: rtl/dmem_wait_fsm.sv
// ----------------------------------------------------------------------------
// dmem_wait_fsm
// Wait-state sequencer for the data memory: IDLE -> WAIT -> DONE -> IDLE.
// Ports:
//   clk, Reset : clock and synchronous active-high reset
//   en         : E bit of the live RAM_CTRL
//   busy       : stall request (IDLE with a new request, and all of WAIT)
//   ready      : high for the single DONE cycle; also the store commit strobe
//   accept     : top level latches the request on this cycle's edge
// ----------------------------------------------------------------------------
module dmem_wait_fsm
   import dmem_pkg::*;
#(
   parameter int WAIT_CYCLES = 1
) (
   input  logic clk,
   input  logic Reset,
   input  logic en,
   output logic busy,
   output logic ready,
   output logic accept
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // State and counter registers; reset parks the sequencer in IDLE with
   // the counter cleared so nothing half-done survives.
   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic. The counter is preloaded with WAIT_CYCLES-1 so that
   // WAIT lasts exactly WAIT_CYCLES cycles. Dropping E while waiting
   // abandons the access: back to IDLE, no DONE, so no ready and no store.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy    = 1'b0;
      ready   = 1'b0;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (en) begin
               accept  = 1'b1;
               busy    = 1'b1;
               cnt_d   = CNT_W'(WAIT_CYCLES - 1);
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            busy = 1'b1;
            if (!en) begin
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE: begin
            ready   = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/data_memory.sv
// ----------------------------------------------------------------------------
// data_memory
// Byte-addressed, big-endian data memory for the MEM stage.
// Ports:
//   clk, Reset               : clock, synchronous active-high reset
//   bus (dmem_if.slave)      : A, DataIn, RAM_CTRL in; DataOut, busy,
//                              ready, misalign out
//   pl_we, pl_addr, pl_data  : byte preload port, commits at any edge
// Parameters: DEPTH (bytes), WAIT_CYCLES (wait-state build only).
// Build option: define DMEM_WAIT_STATE_EN for the multi-cycle access
// sequencer; otherwise every access completes in a single cycle.
// ----------------------------------------------------------------------------
module data_memory
   import dmem_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 1
) (
   input  logic       clk,
   input  logic       Reset,
   dmem_if.slave      bus,
   input  logic       pl_we,
   input  logic [7:0] pl_addr,
   input  logic [7:0] pl_data
);

   logic [7:0]  mem [DEPTH];

   // The request actually being completed: the live bus in the single-cycle
   // build, the latched copy in the wait-state build.
   logic [7:0]  eff_a;
   logic [31:0] eff_data;
   logic        eff_rw;
   logic [1:0]  eff_size;
   logic        done;

   logic [7:0]  base;
   logic [31:0] rd_data;
   logic [3:0]  lane_we;
   logic [7:0]  lane_addr [4];
   logic [7:0]  lane_data [4];

`ifdef DMEM_WAIT_STATE_EN
   logic        accept;
   logic        fsm_busy;
   logic        fsm_ready;
   logic [7:0]  req_a;
   logic [31:0] req_data;
   logic        req_rw;
   logic [1:0]  req_size;

   dmem_wait_fsm #(.WAIT_CYCLES(WAIT_CYCLES)) u_fsm (
      .clk    (clk),
      .Reset  (Reset),
      .en     (bus.RAM_CTRL[CTRL_E]),
      .busy   (fsm_busy),
      .ready  (fsm_ready),
      .accept (accept)
   );

   // Capture the request when the sequencer accepts it, so DONE works from
   // a stable copy even if the pipeline changes A/DataIn meanwhile.
   always_ff @(posedge clk) begin
      if (Reset) begin
         req_a    <= '0;
         req_data <= '0;
         req_rw   <= 1'b0;
         req_size <= SIZE_BYTE;
      end else if (accept) begin
         req_a    <= bus.A;
         req_data <= bus.DataIn;
         req_rw   <= bus.RAM_CTRL[CTRL_RW];
         req_size <= bus.RAM_CTRL[CTRL_SIZE_HI:CTRL_SIZE_LO];
      end
   end

   assign eff_a    = req_a;
   assign eff_data = req_data;
   assign eff_rw   = req_rw;
   assign eff_size = req_size;
   assign done     = fsm_ready;
   assign bus.busy = fsm_busy;
`else
   // WAIT_CYCLES only matters to the sequencer; keep it referenced here.
   logic unused_wait;
   assign unused_wait = (WAIT_CYCLES == 0);

   assign eff_a    = bus.A;
   assign eff_data = bus.DataIn;
   assign eff_rw   = bus.RAM_CTRL[CTRL_RW];
   assign eff_size = bus.RAM_CTRL[CTRL_SIZE_HI:CTRL_SIZE_LO];
   assign done     = bus.RAM_CTRL[CTRL_E];
   assign bus.busy = 1'b0;
`endif

   assign base         = align_addr(eff_a, eff_size);
   assign bus.ready    = done;
   assign bus.misalign = bus.RAM_CTRL[CTRL_E] &&
                         is_misaligned(bus.A, bus.RAM_CTRL[CTRL_SIZE_HI:CTRL_SIZE_LO]);
   assign bus.DataOut  = rd_data;

   // Load path: big-endian assembly from the aligned base, zero-extended.
   // Output stays zero unless a load completes this cycle.
   always_comb begin
      rd_data = '0;
      if (done && !eff_rw) begin
         case (size_e'(eff_size))
            SIZE_BYTE: rd_data = {24'h0, mem[base]};
            SIZE_HALF: rd_data = {16'h0, mem[base], mem[base + 8'd1]};
            SIZE_WORD: rd_data = {mem[base], mem[base + 8'd1],
                                  mem[base + 8'd2], mem[base + 8'd3]};
            default:   rd_data = '0;
         endcase
      end
   end

   // Store path split into four byte lanes; lane 0 is the most significant
   // byte at the aligned base. A store meeting the reset edge is dropped.
   always_comb begin
      lane_we = '0;
      for (int i = 0; i < 4; i++) begin
         lane_addr[i] = base + 8'(i);
         lane_data[i] = '0;
      end
      if (done && eff_rw && !Reset) begin
         case (size_e'(eff_size))
            SIZE_BYTE: begin
               lane_we      = 4'b0001;
               lane_data[0] = eff_data[7:0];
            end
            SIZE_HALF: begin
               lane_we      = 4'b0011;
               lane_data[0] = eff_data[15:8];
               lane_data[1] = eff_data[7:0];
            end
            SIZE_WORD: begin
               lane_we      = 4'b1111;
               lane_data[0] = eff_data[31:24];
               lane_data[1] = eff_data[23:16];
               lane_data[2] = eff_data[15:8];
               lane_data[3] = eff_data[7:0];
            end
            default: lane_we = '0;
         endcase
      end
   end

   // Array writes. Contents are deliberately not reset. The preload write
   // comes last so that, on a collision with a store lane, the preload byte
   // is the one that lands while the other store lanes still commit.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (lane_we[i]) begin
            mem[lane_addr[i]] <= lane_data[i];
         end
      end
      if (pl_we) begin
         mem[pl_addr] <= pl_data;
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// ----------------------------------------------------------------------------
// tb_data_memory
// Directed testbench for data_memory. Works in both builds; the
// wait-state-only steps are guarded by DMEM_WAIT_STATE_EN.
// ----------------------------------------------------------------------------
module tb_data_memory;
   import dmem_pkg::*;

   localparam logic [3:0] LD_B = 4'b1000;
   localparam logic [3:0] LD_H = 4'b1001;
   localparam logic [3:0] LD_W = 4'b1010;
   localparam logic [3:0] LD_R = 4'b1011;
   localparam logic [3:0] ST_B = 4'b1100;
   localparam logic [3:0] ST_H = 4'b1101;
   localparam logic [3:0] ST_W = 4'b1110;
   localparam logic [3:0] ST_R = 4'b1111;

`ifdef DMEM_WAIT_STATE_EN
   localparam int EXP_BUSY = 3;
`else
   localparam int EXP_BUSY = 0;
`endif

   logic       clk = 1'b0;
   logic       Reset;
   logic       pl_we;
   logic [7:0] pl_addr;
   logic [7:0] pl_data;

   int passCount  = 0;
   int checkCount = 0;

   logic [31:0] dout;
   logic        rdy;
   logic        mis;
   int          bc;
   logic        stray;

   dmem_if bus ();

   data_memory #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
      .clk     (clk),
      .Reset   (Reset),
      .bus     (bus),
      .pl_we   (pl_we),
      .pl_addr (pl_addr),
      .pl_data (pl_data)
   );

   // 10-unit clock
   always #5 clk = ~clk;

   // Hard stop in case a wait somewhere never resolves
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: counts it, and counts a pass or reports the failure
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount = checkCount + 1;
      assert (observed === expected) passCount = passCount + 1;
      else $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
   endtask

   // Single byte preload through the side port
   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      pl_we   = 1'b1;
      pl_addr = a;
      pl_data = d;
      @(posedge clk); #1;
      pl_we   = 1'b0;
   endtask

   // Issue one access and hold it until ready (bounded to 10 cycles).
   // Optionally fires a preload in the completing cycle so both land on the
   // same edge. Reports completion data, busy cycles seen and whether
   // DataOut was ever nonzero before completion.
   task automatic applyStimulus(input logic [7:0] a, input logic [31:0] d,
                                input logic [3:0] ctrl, input logic plEn,
                                input logic [7:0] plA, input logic [7:0] plD,
                                output logic [31:0] odata, output logic ordy,
                                output logic omis, output int obusy,
                                output logic ostray);
      bus.A        = a;
      bus.DataIn   = d;
      bus.RAM_CTRL = ctrl;
      ordy   = 1'b0;
      odata  = '0;
      omis   = 1'b0;
      obusy  = 0;
      ostray = 1'b0;
      for (int cyc = 0; cyc < 10 && !ordy; cyc++) begin
         @(negedge clk);
         if (bus.busy === 1'b1) obusy = obusy + 1;
         if (bus.ready === 1'b1) begin
            ordy  = 1'b1;
            odata = bus.DataOut;
            omis  = bus.misalign;
            if (plEn) begin
               pl_we   = 1'b1;
               pl_addr = plA;
               pl_data = plD;
            end
         end else if (bus.DataOut !== 32'h0) begin
            ostray = 1'b1;
         end
         @(posedge clk); #1;
      end
      bus.RAM_CTRL = 4'b0000;
      pl_we        = 1'b0;
   endtask

   // Directed sequence
   initial begin
      Reset        = 1'b1;
      pl_we        = 1'b0;
      pl_addr      = '0;
      pl_data      = '0;
      bus.A        = '0;
      bus.DataIn   = '0;
      bus.RAM_CTRL = 4'b0000;

      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("reset_dataout", bus.DataOut, 32'h0);
      checkOutput("reset_busy", {31'h0, bus.busy}, 32'h0);
      checkOutput("reset_ready", {31'h0, bus.ready}, 32'h0);
      @(posedge clk); #1;
      Reset = 1'b0;

      preload(8'h10, 8'h12);
      preload(8'h11, 8'h34);
      preload(8'h12, 8'h56);
      preload(8'h13, 8'h78);
      preload(8'h21, 8'h00);
      preload(8'h22, 8'h00);
      preload(8'h23, 8'h00);
      preload(8'h30, 8'hC3);
      preload(8'h60, 8'h77);

      // Idle bus with a misaligned address but E=0
      bus.A        = 8'h11;
      bus.RAM_CTRL = 4'b0010;
      @(negedge clk);
      checkOutput("idle_dataout", bus.DataOut, 32'h0);
      checkOutput("idle_ready", {31'h0, bus.ready}, 32'h0);
      checkOutput("idle_misalign", {31'h0, bus.misalign}, 32'h0);
      @(posedge clk); #1;
      bus.RAM_CTRL = 4'b0000;

      applyStimulus(8'h10, 32'h0, LD_W, 1'b0, 8'h0, 8'h0, dout, rdy, mis, bc, stray);
      checkOutput("ldw_10_data", dout, 32'h12345678);
      checkOutput("ldw_10_ready", {31'h0, rdy}, 32'h1);
      checkOutput("ldw_10_misalign", {31'h0, mis}, 32'h0);
      checkOutput("ldw_10_busy_cycles", 32'(bc), 32'(EXP_BUSY));
      checkOutput("ldw_10_early_data", {31'h0, stray}, 32'h0);

      applyStimulus(8'h12, 32'h0, LD_H, 1'b0, 8'h0, 8'h0, dout, rdy, mis, bc, stray);
      checkOutput("ldh_12_data", dout, 32'h00005678);

      applyStimulus(8'h11, 32'h0, LD_B, 1'b0, 8'h0, 8'h0, dout, rdy, mis, bc, stray);
      checkOutput("ldb_11_data", dout, 32'h00000034);
      checkOutput("ldb_11_misalign", {31'h0, mis}, 32'h0);

      applyStimulus(8'h11, 32'h0, LD_W, 1'b0, 8'h0, 8'h0, dout, rdy, mis, bc, stray);
      checkOutput("ldw_11_misalign", {31'h0, mis}, 32'h1);
      checkOutput("ldw_11_data", dout, 32'h12345678);

      applyStimulus(8'h13, 32'h0, LD_H, 1'b0, 8'h0, 8'h0, dout, rdy, mis, bc, stray);
      checkOutput("ldh_13_misalign", {31'h0, mis}, 32'h1);
      checkOutput("ldh_13_data", dout, 32'h00005678);

      applyStimulus(8'h10, 32'h0, LD_R, 1'b0, 8'h0, 8'h0, dout, rdy, mis, bc, stray);
      checkOutput("ldr_ready", {31'h0, rdy}, 32'h1);
      checkOutput("ldr_data", dout, 32'h0);
      checkOutput("ldr_misalign", {31'h0, mis}, 32'h1);

      applyStimulus(8'h20, 32'hAABBCCDD, ST_B, 1'b0, 8'h0, 8'h0, dout, rdy, mis, bc, stray);
      checkOutput("stb_20_ready", {31'h0, rdy}, 32'h1);
      checkOutput("stb_20_dataout", dout, 32'h0);
      applyStimulus(8'h20, 32'h0, LD_W, 1'b0, 8'h0, 8'h0, dout, rdy, mis, bc, stray);
      checkOutput("ldw_20_data", dout, 32'hDD000000);

      applyStimulus(8'h50, 32'hCAFEF00D, ST_W, 1'b0, 8'h0, 8'h0, dout, rdy, mis, bc, stray);
      applyStimulus(8'h50, 32'hFFFFFFFF, ST_R, 1'b0, 8'h0, 8'h0, dout, rdy, mis, bc, stray);
      checkOutput("str_50_ready", {31'h0, rdy}, 32'h1);
      applyStimulus(8'h50, 32'h0, LD_W, 1'b0, 8'h0, 8'h0, dout, rdy, mis, bc, stray);
      checkOutput("ldw_50_data", dout, 32'hCAFEF00D);

      applyStimulus(8'h40, 32'h00001234, ST_H, 1'b1, 8'h41, 8'h55, dout, rdy, mis, bc, stray);
      applyStimulus(8'h40, 32'h0, LD_H, 1'b0, 8'h0, 8'h0, dout, rdy, mis, bc, stray);
      checkOutput("ldh_40_collision", dout, 32'h00001255);

      // Store word to 0x30 cut off by reset
      bus.A        = 8'h30;
      bus.DataIn   = 32'hFFFFFFFF;
      bus.RAM_CTRL = ST_W;
`ifdef DMEM_WAIT_STATE_EN
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("rst_wait_busy", {31'h0, bus.busy}, 32'h1);
      Reset        = 1'b1;
      bus.RAM_CTRL = 4'b0000;
`else
      Reset        = 1'b1;
`endif
      @(posedge clk); #1;
      Reset        = 1'b0;
      bus.RAM_CTRL = 4'b0000;
      @(negedge clk);
      checkOutput("rst_store_busy", {31'h0, bus.busy}, 32'h0);
      checkOutput("rst_store_ready", {31'h0, bus.ready}, 32'h0);
      @(posedge clk); #1;
      applyStimulus(8'h30, 32'h0, LD_B, 1'b0, 8'h0, 8'h0, dout, rdy, mis, bc, stray);
      checkOutput("ldb_30_after_rst", dout, 32'h000000C3);
      checkOutput("ldb_30_busy_cycles", 32'(bc), 32'(EXP_BUSY));

`ifdef DMEM_WAIT_STATE_EN
      // Store byte to 0x60 abandoned by dropping E in WAIT
      bus.A        = 8'h60;
      bus.DataIn   = 32'h00000011;
      bus.RAM_CTRL = ST_B;
      @(posedge clk); #1;
      bus.RAM_CTRL = 4'b0000;
      @(negedge clk);
      checkOutput("abort_ready_wait", {31'h0, bus.ready}, 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("abort_ready_idle", {31'h0, bus.ready}, 32'h0);
      checkOutput("abort_busy_idle", {31'h0, bus.busy}, 32'h0);
      @(posedge clk); #1;
      applyStimulus(8'h60, 32'h0, LD_B, 1'b0, 8'h0, 8'h0, dout, rdy, mis, bc, stray);
      checkOutput("ldb_60_after_abort", dout, 32'h00000077);
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter DEPTH, default 256, byte capacity; address width 8 bits.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, number of wait cycles per access; only used when DMEM_WAIT_STATE_EN is defined.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port A, input, 8, byte address from MEM_ALU_OUT.
REQ-006 SHALL have port DataIn, input, 32, store data from MEM_RB.
REQ-007 SHALL have port RAM_CTRL, input, 4, access control: [3]=E enable, [2]=RW (1=store), [1:0]=size (00 byte, 01 half, 10 word, 11 reserved).
REQ-008 SHALL have port DataOut, output, 32, load data.
REQ-009 SHALL have port busy, output, 1, stall request to the pipeline.
REQ-010 SHALL have port ready, output, 1, access completes this cycle.
REQ-011 SHALL have port misalign, output, 1, address not aligned to size, or reserved size.
REQ-012 SHALL have port pl_we, input, 1, preload byte write enable.
REQ-013 SHALL have port pl_addr, input, 8, preload byte address.
REQ-014 SHALL have port pl_data, input, 8, preload byte.

Function
REQ-015 SHALL store bytes big-endian: word at A holds A in [31:24] through A+3 in [7:0].
REQ-016 SHALL force alignment: half ignores A[0], word ignores A[1:0]; misalign=1 combinationally when E=1 and the ignored bits are nonzero, or when size=11.
REQ-017 SHALL zero-extend byte and half loads into DataOut.
REQ-018 SHALL store DataIn[7:0] for byte, DataIn[15:0] for half, and the full word for word stores.
REQ-019 SHALL treat size=11 as no-op: no write, DataOut=0, ready still asserted on completion.
REQ-020 SHALL drive DataOut=0 whenever no load completes in the current cycle.
REQ-021 SHALL commit pl_we writes at the clock edge, in any state.
REQ-022 SHALL resolve a preload and a store to the same byte in the same edge with the preload value winning; other bytes of the store still commit.

Reset
REQ-023 SHALL on Reset=1 at a clock edge: FSM to IDLE, wait counter=0, latched request cleared, DataOut=0, busy=0, ready=0.
REQ-024 SHALL NOT clear memory contents on reset, and SHALL drop any store still pending at the reset edge.

Configuration
REQ-025 SHALL, without DMEM_WAIT_STATE_EN: perform every access in a single cycle; busy=0 always; ready=E; load data is combinational from the array; store commits at the edge ending the cycle.
REQ-026 SHALL, with DMEM_WAIT_STATE_EN: use FSM IDLE->WAIT->DONE->IDLE.
REQ-027 SHALL, with DMEM_WAIT_STATE_EN, in IDLE with E=1: latch A, DataIn and RAM_CTRL; busy=1 combinationally; load counter with WAIT_CYCLES-1; go to WAIT.
REQ-028 SHALL, with DMEM_WAIT_STATE_EN, in WAIT: busy=1; decrement counter; go to DONE when counter=0.
REQ-029 SHALL, with DMEM_WAIT_STATE_EN, in DONE: busy=0, ready=1; DataOut from latched request; store commits at the edge ending DONE; next state IDLE.
REQ-030 SHALL, with DMEM_WAIT_STATE_EN, if E drops during WAIT: abort to IDLE without store and without ready; a new request is accepted only from IDLE.

Structure
REQ-031 SHALL take from shared package dmem_pkg: RAM_CTRL bit positions, size encodings and the FSM state enum.
REQ-032 SHALL implement the FSM and counter in sub-module dmem_wait_fsm, instantiated only when DMEM_WAIT_STATE_EN is defined.

Verification
REQ-033 SHALL cover, without macro: preload 0x10..0x13 = 12 34 56 78, load word A=0x10 -> DataOut=0x12345678, ready=1 same cycle.
REQ-034 SHALL cover: load half A=0x12 -> 0x00005678; load byte A=0x11 -> 0x00000034; load word A=0x11 -> misalign=1, data from 0x10.
REQ-035 SHALL cover: store byte DataIn=0xAABBCCDD at A=0x20, then load word 0x20 -> 0xDD000000.
REQ-036 SHALL cover, with macro and WAIT_CYCLES=2: load request -> busy=1 for 3 cycles, ready=1 on the 4th with correct data; DataOut=0 elsewhere.
REQ-037 SHALL cover, with macro: Reset during WAIT of store 0xFFFFFFFF to 0x30 -> memory at 0x30 unchanged, FSM in IDLE, busy=0.
REQ-038 SHALL cover: same-edge preload 0x55 to 0x41 and store half 0x1234 to 0x40 -> load half 0x40 returns 0x00001255.
